// File: rtl/if_fetch_unit.sv
// Purpose: instruction-fetch front end. It holds the PC, fetches imem[pc] over req/ack, and hands the word to decode.
// Latency: inst_valid rises one cycle after the ack cycle. With zero-wait memory a fetch takes 2 cycles per instruction.
// Backpressure: decode stalls by holding inst_ready low in HOLD, which freezes every register. Memory stalls by withholding ack.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        fetch_err,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } state_t;

  // MAX_WAIT is limited to 1..255, so an 8-bit wait counter always holds it.
  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  state_t     state;
  logic [7:0] wait_cnt;

  // The fetch address is the architectural PC. The next value comes only from the NPC unit.
  assign imem_addr = pc;

  // Fetch sequencer. imem_req and inst_valid are registered together with the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      inst       <= '0;
      fetch_cnt  <= '0;
      fetch_err  <= 1'b0;
      wait_cnt   <= '0;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end

        REQ: begin
          if (imem_ack) begin
            // An ack always wins, even in the cycle that would otherwise time out.
            inst       <= imem_rdata;
            wait_cnt   <= '0;
            state      <= HOLD;
            imem_req   <= 1'b0;
            inst_valid <= 1'b1;
          end else if (wait_cnt + 8'd1 == WAIT_LIMIT) begin
            wait_cnt  <= wait_cnt + 8'd1;
            fetch_err <= 1'b1;
            state     <= ERR;
            imem_req  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        HOLD: begin
          if (inst_ready) begin
            // A misaligned target is still loaded, so it can be inspected after the error.
            pc         <= npc;
            fetch_cnt  <= fetch_cnt + 32'd1;
            inst_valid <= 1'b0;
            if (npc[1:0] != 2'b00) begin
              fetch_err <= 1'b1;
              state     <= ERR;
            end else begin
              state    <= REQ;
              imem_req <= 1'b1;
            end
          end
        end

        ERR: begin
          // Terminal state. Only reset leaves it, and pc and fetch_cnt stay frozen.
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
        end

        default: begin
          state      <= ERR;
          fetch_err  <= 1'b1;
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit. Fetched words are queued when memory acks and checked when decode accepts.
// Stimulus is driven 1 time unit after each rising edge, and outputs are sampled at that same point.
// MAX_WAIT is set to 4 so that the timeout and the ack-on-last-cycle cases stay short.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] npc;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic        fetch_err;
  logic [31:0] fetch_cnt;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;
  logic [31:0] exp_q[$];

  if_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .MAX_WAIT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .npc        (npc),
    .pc         (pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .fetch_err  (fetch_err),
    .fetch_cnt  (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered while the DUT is in REQ. The task acks after ack_wait cycles and stalls decode for ready_wait cycles.
  // It then accepts the instruction with npc = next_pc.
  task automatic fetch_one(input int ack_wait, input int ready_wait, input logic [31:0] next_pc);
    logic [31:0] word;
    chk("req_start", {31'd0, imem_req}, 32'd1);
    chk("addr_start", imem_addr, exp_pc);
    for (int i = 0; i < ack_wait; i++) begin
      imem_ack = 1'b0;
      step();
      chk("req_wait", {31'd0, imem_req}, 32'd1);
      chk("err_wait", {31'd0, fetch_err}, 32'd0);
      chk("pc_wait", pc, exp_pc);
    end
    word = exp_pc ^ 32'hA5A5_0000;
    imem_ack   = 1'b1;
    imem_rdata = word;
    exp_q.push_back(word);
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk("hold_valid", {31'd0, inst_valid}, 32'd1);
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < ready_wait; i++) begin
      inst_ready = 1'b0;
      step();
      chk("bp_valid", {31'd0, inst_valid}, 32'd1);
      chk("bp_inst", inst, exp_q[0]);
      chk("bp_pc", pc, exp_pc);
      chk("bp_cnt", fetch_cnt, exp_cnt);
    end
    chk("acc_inst", inst, exp_q.pop_front());
    inst_ready = 1'b1;
    npc        = next_pc;
    step();
    inst_ready = 1'b0;
    exp_pc  = next_pc;
    exp_cnt = exp_cnt + 32'd1;
    chk("acc_pc", pc, exp_pc);
    chk("acc_cnt", fetch_cnt, exp_cnt);
    chk("acc_req", {31'd0, imem_req}, 32'd1);
    chk("acc_addr", imem_addr, exp_pc);
    chk("acc_valid", {31'd0, inst_valid}, 32'd0);
    chk("acc_err", {31'd0, fetch_err}, 32'd0);
  endtask

  initial begin
    rst        = 1'b0;
    npc        = 32'd0;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    inst_ready = 1'b0;
    exp_pc     = 32'd0;
    exp_cnt    = 32'd0;

    // Reset held for three cycles.
    step(); step(); step();
    chk("rst_pc", pc, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_cnt", fetch_cnt, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    rst = 1'b1;
    step();
    chk("rel_req", {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'd0);

    // Sequential fetch with zero-wait memory. Each fetch_one takes exactly two cycles.
    fetch_one(0, 0, 32'd4);
    fetch_one(0, 0, 32'd8);
    fetch_one(0, 0, 32'd12);
    chk("seq_cnt3", fetch_cnt, 32'd3);

    // Ack arrives on the 4th REQ cycle (ack beats timeout), and decode stalls for 4 cycles.
    fetch_one(3, 4, 32'd16);

    // Jump.
    fetch_one(0, 0, 32'h0000_0040);

    // Timeout: 4 REQ cycles without an ack.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_req", {31'd0, imem_req}, 32'd1);
      chk("to_err_lo", {31'd0, fetch_err}, 32'd0);
    end
    step();
    chk("to_err", {31'd0, fetch_err}, 32'd1);
    chk("to_req_lo", {31'd0, imem_req}, 32'd0);
    imem_ack   = 1'b1;
    inst_ready = 1'b1;
    step();
    step();
    chk("err_pc", pc, 32'h0000_0040);
    chk("err_valid", {31'd0, inst_valid}, 32'd0);
    chk("err_cnt", fetch_cnt, exp_cnt);
    chk("err_sticky", {31'd0, fetch_err}, 32'd1);
    imem_ack   = 1'b0;
    inst_ready = 1'b0;

    // Reset out of ERR.
    rst = 1'b0;
    step();
    chk("rst2_err", {31'd0, fetch_err}, 32'd0);
    chk("rst2_pc", pc, 32'd0);
    chk("rst2_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b1;
    exp_pc  = 32'd0;
    exp_cnt = 32'd0;
    step();
    chk("rel2_req", {31'd0, imem_req}, 32'd1);

    // Reset asserted while in HOLD.
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 1'b0;
    chk("mh_valid", {31'd0, inst_valid}, 32'd1);
    chk("mh_inst", inst, 32'h1234_5678);
    rst = 1'b0;
    step();
    chk("mh_rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("mh_rst_pc", pc, 32'd0);
    chk("mh_rst_inst", inst, 32'd0);
    rst = 1'b1;
    step();
    chk("mh_rel_req", {31'd0, imem_req}, 32'd1);
    chk("mh_rel_addr", imem_addr, 32'd0);

    // Misaligned npc on accept.
    imem_ack   = 1'b1;
    imem_rdata = 32'hCAFE_0000;
    step();
    imem_ack   = 1'b0;
    inst_ready = 1'b1;
    npc        = 32'h0000_0042;
    step();
    chk("mis_err", {31'd0, fetch_err}, 32'd1);
    chk("mis_pc", pc, 32'h0000_0042);
    chk("mis_cnt", fetch_cnt, 32'd1);
    imem_ack = 1'b1;
    npc      = 32'h0000_0100;
    for (int i = 0; i < 10; i++) begin
      chk("mis_req_lo", {31'd0, imem_req}, 32'd0);
      chk("mis_valid_lo", {31'd0, inst_valid}, 32'd0);
      step();
    end
    chk("mis_pc_frozen", pc, 32'h0000_0042);
    chk("mis_cnt_frozen", fetch_cnt, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
